pipeline_control: RTL and testbench
===================================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, named CLK and nRST.
REQ-002 CLK  input  1  clock; all state updates on the rising edge.
REQ-003 nRST  input  1  async active-low reset.
REQ-004 ihit  input  1  instruction fetch complete this cycle.
REQ-005 dhit  input  1  data access complete this cycle.
REQ-006 EXMEM_dREN, EXMEM_dWEN  input  1 each  data access pending in MEM.
REQ-007 StallLW  input  2  hazard unit load-use request; nonzero means stall.
REQ-008 branch_taken  input  1  branch/jump redirect resolved in EX/MEM.
REQ-009 MEMWB_halt  input  1  halt instruction reached WB.
REQ-010 pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en  output  1 each  per-stage advance enables.
REQ-011 IFID_flush, IDEX_flush, EXMEM_flush  output  1 each  load a bubble instead of the incoming stage.
REQ-012 halt  output  1  registered; sticky CPU halt.
REQ-013 stall_cnt  output  32  saturating count of frozen-PC cycles.

Function
REQ-014 States SHALL be RUN, MEMWAIT and HALTED; all enable and flush outputs SHALL be combinational from state, redirect flag and inputs.
REQ-015 dpend SHALL be (EXMEM_dREN | EXMEM_dWEN) & ~dhit.
REQ-016 Priority each RUN cycle: MEMWB_halt > dpend > branch_taken > StallLW > ~ihit > normal.
REQ-017 MEMWB_halt in RUN or MEMWAIT: all enables 0 this cycle; next state HALTED; halt=1 from the next cycle.
REQ-018 HALTED: all enables and flushes 0; halt=1; state held until nRST.
REQ-019 dpend: all enables 0, flushes 0; next state MEMWAIT.
REQ-020 MEMWAIT: outputs as REQ-019 while dpend; on dhit, full advance this cycle (all enables 1, regardless of ihit except REQ-024); next state RUN.
REQ-021 branch_taken: all enables 1, IFID_flush=IDEX_flush=EXMEM_flush=1; redirect flag set if ihit=0.
REQ-022 StallLW!=0: pc_en=0, IFID_en=0, IDEX_en=1 with IDEX_flush=1, EXMEM_en=MEMWB_en=1.
REQ-023 ~ihit: pc_en=0, IFID_en=1 with IFID_flush=1, downstream enables 1.
REQ-024 Redirect flag set: IFID_flush forced 1 on every cycle with IFID_en=1; cleared on the first cycle with ihit=1 (that fetch discarded).
REQ-025 Normal: all enables 1, all flushes 0.
REQ-026 A flush output SHALL never be 1 while its stage enable is 0.
REQ-027 stall_cnt SHALL increment by 1 on each cycle with pc_en=0 and state != HALTED, saturating at 32'hFFFF_FFFF.
REQ-028 branch_taken coincident with StallLW: branch wins; IDEX_flush covers the load-use bubble.

Reset
REQ-029 nRST low SHALL asynchronously force state=RUN, halt=0, redirect=0, stall_cnt=0.
REQ-030 Reset mid-MEMWAIT or HALTED SHALL return to RUN with no residual stall or flush.
REQ-031 Combinational outputs during reset SHALL follow RUN rules from current inputs.

Structure
REQ-032 State enum pctrl_state_t (RUN, MEMWAIT, HALTED) SHALL live in cpu_types_pkg.
REQ-033 Block SHALL be a single module plus one sub-module sat_counter (32-bit saturating incrementer, CLK/nRST, enable input).
REQ-034 Signal names SHALL match hazard_unit port names where shared (StallLW, EXMEM_dREN, EXMEM_dWEN).

Verification
REQ-035 Reset with ihit=1, all else 0 -> all enables 1, flushes 0, halt=0, stall_cnt=0.
REQ-036 EXMEM_dREN=1, dhit=0 for 3 cycles then dhit=1 -> 3 cycles all enables 0, state MEMWAIT, stall_cnt=3; 4th cycle all enables 1, RUN.
REQ-037 StallLW=2'b01, ihit=1 one cycle -> pc_en=0, IFID_en=0, IDEX_flush=1, EXMEM_en=1; stall_cnt +1.
REQ-038 branch_taken=1 with ihit=0, then ihit=0, then ihit=1 -> three flushes first cycle; IFID_flush=1 on both following cycles; redirect clear after ihit.
REQ-039 MEMWB_halt=1 -> next cycle halt=1, all enables 0; toggle other inputs 10 cycles -> unchanged; nRST pulse -> RUN, halt=0.
REQ-040 Preload stall_cnt near saturation (force 32'hFFFF_FFFE), hold ihit=0 3 cycles -> stall_cnt stops at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU control types: pipeline-control FSM state, stage-control bundle,
// and the data-access-pending helper used by the control unit.
package cpu_types_pkg;

  localparam int STALL_CNT_W = 32;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALTED  = 2'd2
  } pctrl_state_t;

  typedef struct packed {
    logic pcEn;
    logic ifidEn;
    logic idexEn;
    logic exmemEn;
    logic memwbEn;
    logic ifidFlush;
    logic idexFlush;
    logic exmemFlush;
  } stageCtrl_t;

  // A MEM-stage access is outstanding until the cache answers with dhit.
  function automatic logic dataPending(input logic dREN, input logic dWEN,
                                       input logic dhit);
    return (dREN | dWEN) & ~dhit;
  endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// Handshake bundle between the datapath (master) and pipeline control (slave).
interface pipeline_control_if;
  import cpu_types_pkg::*;

  logic                   ihit;
  logic                   dhit;
  logic                   EXMEM_dREN;
  logic                   EXMEM_dWEN;
  logic [1:0]             StallLW;
  logic                   branch_taken;
  logic                   MEMWB_halt;
  logic                   pc_en;
  logic                   IFID_en;
  logic                   IDEX_en;
  logic                   EXMEM_en;
  logic                   MEMWB_en;
  logic                   IFID_flush;
  logic                   IDEX_flush;
  logic                   EXMEM_flush;
  logic                   halt;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output ihit, dhit, EXMEM_dREN, EXMEM_dWEN, StallLW, branch_taken, MEMWB_halt,
    input  pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
           IFID_flush, IDEX_flush, EXMEM_flush, halt, stall_cnt
  );

  modport slave (
    input  ihit, dhit, EXMEM_dREN, EXMEM_dWEN, StallLW, branch_taken, MEMWB_halt,
    output pc_en, IFID_en, IDEX_en, EXMEM_en, MEMWB_en,
           IFID_flush, IDEX_flush, EXMEM_flush, halt, stall_cnt
  );
endinterface

// File: rtl/pipeline_control_sat_counter.sv
// Saturating up-counter: counts enabled cycles and sticks at all-ones.
module sat_counter #(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  output logic [DATA_W-1:0] count
);

  logic [DATA_W-1:0] countQ;

  // Increment while enabled, holding once the maximum is reached
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      countQ <= '0;
    end else if (en && (countQ != '1)) begin
      countQ <= countQ + DATA_W'(1);
    end
  end

  assign count = countQ;

endmodule

// File: rtl/pipeline_control.sv
// Pipeline control: per-stage advance/flush decode, memory-wait and halt FSM,
// post-branch fetch discard, and a frozen-PC cycle counter.
module pipeline_control
  import cpu_types_pkg::*;
(
  input logic               CLK,
  input logic               nRST,
  pipeline_control_if.slave bus
);

  pctrl_state_t           stateQ;
  logic                   haltQ;
  logic                   redirectQ;
  logic                   dPend;
  logic                   takeBranch;
  logic                   stallCntEn;
  stageCtrl_t             ctrl;
  logic [STALL_CNT_W-1:0] stallCnt;

  assign dPend = dataPending(bus.EXMEM_dREN, bus.EXMEM_dWEN, bus.dhit);

  // Decode this cycle's stage enables and bubble insertion from state and inputs
  always_comb begin
    ctrl       = '0;
    takeBranch = 1'b0;
    case (stateQ)
      RUN: begin
        if (bus.MEMWB_halt || dPend) begin
          ctrl = '0;
        end else if (bus.branch_taken) begin
          // Redirect squashes all three younger stages; this also absorbs
          // any load-use bubble requested in the same cycle.
          ctrl       = '{pcEn: 1'b1, ifidEn: 1'b1, idexEn: 1'b1, exmemEn: 1'b1,
                         memwbEn: 1'b1, ifidFlush: 1'b1, idexFlush: 1'b1,
                         exmemFlush: 1'b1};
          takeBranch = 1'b1;
        end else if (bus.StallLW != 2'b00) begin
          ctrl = '{pcEn: 1'b0, ifidEn: 1'b0, idexEn: 1'b1, exmemEn: 1'b1,
                   memwbEn: 1'b1, ifidFlush: 1'b0, idexFlush: 1'b1,
                   exmemFlush: 1'b0};
        end else if (!bus.ihit) begin
          ctrl = '{pcEn: 1'b0, ifidEn: 1'b1, idexEn: 1'b1, exmemEn: 1'b1,
                   memwbEn: 1'b1, ifidFlush: 1'b1, idexFlush: 1'b0,
                   exmemFlush: 1'b0};
        end else begin
          ctrl = '{pcEn: 1'b1, ifidEn: 1'b1, idexEn: 1'b1, exmemEn: 1'b1,
                   memwbEn: 1'b1, ifidFlush: 1'b0, idexFlush: 1'b0,
                   exmemFlush: 1'b0};
        end
      end
      MEMWAIT: begin
        // Once the data access lands, the whole pipe moves regardless of ihit.
        if (!bus.MEMWB_halt && !dPend) begin
          ctrl = '{pcEn: 1'b1, ifidEn: 1'b1, idexEn: 1'b1, exmemEn: 1'b1,
                   memwbEn: 1'b1, ifidFlush: 1'b0, idexFlush: 1'b0,
                   exmemFlush: 1'b0};
        end
      end
      default: ctrl = '0;
    endcase
    // A fetch issued before the redirect resolved is stale: never let it into IF/ID.
    if (redirectQ && ctrl.ifidEn) begin
      ctrl.ifidFlush = 1'b1;
    end
  end

  // Control FSM with registered halt and redirect-pending flag
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stateQ    <= RUN;
      haltQ     <= 1'b0;
      redirectQ <= 1'b0;
    end else begin
      case (stateQ)
        RUN, MEMWAIT: begin
          if (bus.MEMWB_halt) begin
            stateQ <= HALTED;
            haltQ  <= 1'b1;
          end else if (dPend) begin
            stateQ <= MEMWAIT;
          end else begin
            stateQ <= RUN;
          end
          if (takeBranch && !bus.ihit) begin
            redirectQ <= 1'b1;
          end else if (bus.ihit) begin
            redirectQ <= 1'b0;
          end
        end
        default: begin
          stateQ <= HALTED;
          haltQ  <= 1'b1;
        end
      endcase
    end
  end

  assign stallCntEn = !ctrl.pcEn && (stateQ != HALTED);

  sat_counter #(.DATA_W(STALL_CNT_W)) uStallCnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .en    (stallCntEn),
    .count (stallCnt)
  );

  assign bus.pc_en       = ctrl.pcEn;
  assign bus.IFID_en     = ctrl.ifidEn;
  assign bus.IDEX_en     = ctrl.idexEn;
  assign bus.EXMEM_en    = ctrl.exmemEn;
  assign bus.MEMWB_en    = ctrl.memwbEn;
  assign bus.IFID_flush  = ctrl.ifidFlush;
  assign bus.IDEX_flush  = ctrl.idexFlush;
  assign bus.EXMEM_flush = ctrl.exmemFlush;
  assign bus.halt        = haltQ;
  assign bus.stall_cnt   = stallCnt;

endmodule

// File: tb/tb_pipeline_control.sv
// Directed bench for pipeline_control: stimulus pushes expected outputs into a
// queue, a monitor on the falling edge pops and compares.
module tb_pipeline_control;

  logic CLK;
  logic nRST;

  pipeline_control_if pif();

  pipeline_control dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (pif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [4:0]  en;
    logic [2:0]  fl;
    logic        h;
    logic [31:0] c;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Drive one cycle of inputs just after the rising edge and queue the
  // outputs expected when the monitor samples at the following falling edge.
  task automatic cyc(input string tag, input logic rstn, input logic ih,
                     input logic dh, input logic dr, input logic dw,
                     input logic [1:0] slw, input logic br, input logic hl,
                     input logic [4:0] en, input logic [2:0] fl,
                     input logic h, input logic [31:0] c);
    exp_t e;
    @(posedge CLK);
    #1;
    nRST             = rstn;
    pif.ihit         = ih;
    pif.dhit         = dh;
    pif.EXMEM_dREN   = dr;
    pif.EXMEM_dWEN   = dw;
    pif.StallLW      = slw;
    pif.branch_taken = br;
    pif.MEMWB_halt   = hl;
    e.tag = tag;
    e.en  = en;
    e.fl  = fl;
    e.h   = h;
    e.c   = c;
    q.push_back(e);
  endtask

  // Monitor: compare every queued expectation and the flush/enable invariant
  initial begin
    forever begin
      @(negedge CLK);
      begin
        logic [4:0] aEn;
        logic [2:0] aFl;
        exp_t       e;
        aEn = {pif.pc_en, pif.IFID_en, pif.IDEX_en, pif.EXMEM_en, pif.MEMWB_en};
        aFl = {pif.IFID_flush, pif.IDEX_flush, pif.EXMEM_flush};
        checks++;
        if ((aFl & ~aEn[3:1]) != 3'b000) begin
          errors++;
          $display("FAIL flush_without_enable: flush=%b en=%b required no flush on a disabled stage", aFl, aEn);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          checks++;
          if (aEn !== e.en) begin
            errors++;
            $display("FAIL %s enables: got %b want %b", e.tag, aEn, e.en);
          end
          checks++;
          if (aFl !== e.fl) begin
            errors++;
            $display("FAIL %s flushes: got %b want %b", e.tag, aFl, e.fl);
          end
          checks++;
          if (pif.halt !== e.h) begin
            errors++;
            $display("FAIL %s halt: got %b want %b", e.tag, pif.halt, e.h);
          end
          checks++;
          if (pif.stall_cnt !== e.c) begin
            errors++;
            $display("FAIL %s stall_cnt: got %h want %h", e.tag, pif.stall_cnt, e.c);
          end
        end
      end
    end
  end

  // Stimulus. Enables are {pc,IFID,IDEX,EXMEM,MEMWB}; flushes are {IFID,IDEX,EXMEM}.
  initial begin
    nRST             = 1'b0;
    pif.ihit         = 1'b1;
    pif.dhit         = 1'b0;
    pif.EXMEM_dREN   = 1'b0;
    pif.EXMEM_dWEN   = 1'b0;
    pif.StallLW      = 2'b00;
    pif.branch_taken = 1'b0;
    pif.MEMWB_halt   = 1'b0;

    // Reset: RUN rules from current inputs
    cyc("reset",      0, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'd0);
    cyc("idle0",      1, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'd0);

    // Load miss: three frozen cycles, then full advance
    cyc("dpend1",     1, 1, 0, 1, 0, 2'b00, 0, 0, 5'b00000, 3'b000, 0, 32'd0);
    cyc("memwait2",   1, 1, 0, 1, 0, 2'b00, 0, 0, 5'b00000, 3'b000, 0, 32'd1);
    cyc("memwait3",   1, 1, 0, 1, 0, 2'b00, 0, 0, 5'b00000, 3'b000, 0, 32'd2);
    cyc("memdone",    1, 1, 1, 1, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'd3);
    cyc("idle1",      1, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'd3);

    // Load-use stall
    cyc("loaduse",    1, 1, 0, 0, 0, 2'b01, 0, 0, 5'b00111, 3'b010, 0, 32'd3);
    cyc("idle2",      1, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'd4);

    // Branch while fetch outstanding: stale fetch discarded when it arrives
    cyc("branch",     1, 0, 0, 0, 0, 2'b00, 1, 0, 5'b11111, 3'b111, 0, 32'd4);
    cyc("redir_miss", 1, 0, 0, 0, 0, 2'b00, 0, 0, 5'b01111, 3'b100, 0, 32'd4);
    cyc("redir_hit",  1, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b100, 0, 32'd5);
    cyc("redir_clr",  1, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'd5);

    // Branch beats load-use
    cyc("br_lw",      1, 1, 0, 0, 0, 2'b10, 1, 0, 5'b11111, 3'b111, 0, 32'd5);
    cyc("idle3",      1, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'd5);
    cyc("imiss",      1, 0, 0, 0, 0, 2'b00, 0, 0, 5'b01111, 3'b100, 0, 32'd5);

    // Data pending beats branch and load-use; completion advances despite ihit=0
    cyc("dp_over_br", 1, 1, 0, 0, 1, 2'b01, 1, 0, 5'b00000, 3'b000, 0, 32'd6);
    cyc("mw_noihit",  1, 0, 1, 0, 1, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'd7);
    cyc("idle4",      1, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'd7);

    // Halt: sticky, ignores all inputs until reset
    cyc("halt_req",   1, 1, 0, 0, 0, 2'b00, 0, 1, 5'b00000, 3'b000, 0, 32'd7);
    for (int i = 0; i < 10; i++) begin
      cyc("halted", 1, i[0], i[1], i[0], i[2], i[1:0], ~i[0], i[1],
          5'b00000, 3'b000, 1, 32'd8);
    end
    cyc("halt_rst",   0, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'd0);
    cyc("post_rst",   1, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'd0);

    // Reset in the middle of a memory wait
    cyc("mw_enter",   1, 1, 0, 1, 0, 2'b00, 0, 0, 5'b00000, 3'b000, 0, 32'd0);
    cyc("mw_rst",     0, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'd0);
    cyc("mw_post",    1, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'd0);

    // Counter saturation from a preloaded value
    cyc("preload",    1, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'hFFFF_FFFE);
    force dut.uStallCnt.countQ = 32'hFFFF_FFFE;
    cyc("released",   1, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'hFFFF_FFFE);
    release dut.uStallCnt.countQ;
    cyc("sat1",       1, 0, 0, 0, 0, 2'b00, 0, 0, 5'b01111, 3'b100, 0, 32'hFFFF_FFFE);
    cyc("sat2",       1, 0, 0, 0, 0, 2'b00, 0, 0, 5'b01111, 3'b100, 0, 32'hFFFF_FFFF);
    cyc("sat3",       1, 0, 0, 0, 0, 2'b00, 0, 0, 5'b01111, 3'b100, 0, 32'hFFFF_FFFF);
    cyc("sat_hold",   1, 1, 0, 0, 0, 2'b00, 0, 0, 5'b11111, 3'b000, 0, 32'hFFFF_FFFF);

    // Let the monitor drain, bounded
    for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
